voice_alloc: RTL and testbench
==============================

Name: voice_alloc

Overview:
- Polyphonic voice scheduler between the score/event source and NVOICE parallel note+env voice slices.
- Accepts note-on/note-off events through a valid/ready handshake.
- Assigns each note-on to a voice slice, in order of preference: retrigger a matching voice, else a free voice, else steal the oldest voice.
- Drives each slice's pitch period (cyc) and attack strobe, so several notes share the fixed set of synthesis voices feeding the mixer/dsm.

Parameters:
- NVOICE, 4, number of voice slices (2..8)
- CYC_W, 16, width of the note period word (matches note cyc input)
- AGE_W, 8, width of per-voice age counter (saturating)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick  in  1  one-cycle strobe at envelope rate; ages voices and retires attack pulses
- ev_valid  in  1  event present
- ev_ready  out  1  block can accept event
- ev_on  in  1  1 = note-on, 0 = note-off
- ev_cyc  in  CYC_W  note period of event
- voice_cyc  out  NVOICE*CYC_W  packed period per voice; voice i at [i*CYC_W +: CYC_W]
- voice_attack  out  NVOICE  per-voice attack level to env
- voice_active  out  NVOICE  voice holds a sounding (not released) note
- steal  out  1  one-cycle pulse when a note-on stole an active voice

Behaviour:
- Reset: all outputs 0, except ev_ready = 1 from the cycle after rst deasserts. All voice_cyc = 0, ages = 0, FSM = IDLE. Reset mid-operation discards any in-flight event.
- FSM states: IDLE, SEARCH, COMMIT.
  - ev_ready = 1 only in IDLE.
  - Transfer occurs when ev_valid & ev_ready at cycle T; the event is registered and the FSM goes to SEARCH.
  - T+1, SEARCH: registered voice index and action are computed; go to COMMIT.
  - T+2, COMMIT: voice registers are written; go to IDLE.
  - Updated outputs and ev_ready = 1 are visible at T+3, so the maximum rate is one event per 3 cycles.
- Note-on selection, in priority order:
  - (a) A voice with voice_active = 1 and voice_cyc == ev_cyc: retrigger that voice.
  - (b) Else the lowest-index voice with voice_active = 0: free voice.
  - (c) Else the active voice with the largest age, ties broken by lowest index: steal. steal pulses at T+3 for one cycle.
- On note-on commit to voice i:
  - voice_cyc[i] = ev_cyc
  - voice_active[i] = 1
  - age[i] = 0
  - voice_attack[i] = 1
- Note-off:
  - Lowest-index active voice with voice_cyc == ev_cyc: voice_active cleared. voice_cyc is held, so the released note decays through env; age is not reset.
  - No match: event consumed, no state change.
- Age: on tick, each voice age increments, saturating at 2^AGE_W-1. This includes released voices, so freed voices are not preferred for stealing over older ones. Voice stealing (c) only considers active voices.
- voice_attack[i]: set at COMMIT, cleared on the first tick strictly after the set cycle. Guarantees the level is held across at least one tick edge seen by the slow-rate env.
- Same-cycle collisions:
  - tick in the COMMIT cycle: commit wins for that voice. age = 0, attack set and not cleared by this tick. Other voices age normally.
  - ev_valid while not IDLE: ignored (ready = 0); the source must hold the event.
- Width rules: all comparisons are unsigned, exact CYC_W-bit equality. An ev_cyc of 0 is a legal period and is treated like any other.

Decomposition:
- Shared include (def.v): default NVOICE, CYC_W, AGE_W as `define constants; FSM state encodings (2 bits).
- One sub-module, voice_pick: purely combinational priority selector.
  - Inputs: active mask, packed cyc, packed age, ev_cyc.
  - Outputs: match_hit/match_idx, free_hit/free_idx, oldest_idx.
- voice_alloc registers voice_pick's result in SEARCH.

Test Plan:
- Reset then note-on cyc=1000: ev_ready low T..T+2. At T+3: voice_cyc[0]=1000, voice_active=0001, voice_attack=0001, steal=0.
- Four note-ons 100, 200, 300, 400, then tick: voices 0..3 filled in order; attack=0000 after the tick; active=1111.
- With all four active, 3 ticks, then note-on 500: voice 0 (oldest, lowest index on age tie) gets cyc=500; steal pulses exactly one cycle; age[0]=0.
- Note-off 200: active=1101, voice_cyc[1] still 200. Next note-on 600 goes to voice 1 (free), not a steal. Note-off 999 (no match): no output change.
- Note-on 300 while voice 2 is active with 300: retrigger voice 2, attack[2]=1, age[2]=0, no other voice changes.
- tick coincident with COMMIT: attack stays 1 past that tick and clears on the next one. Assert rst during SEARCH: all outputs 0 next cycle and the event is not applied.

Source files
------------

// File: rtl/voice_alloc_pkg.sv
// Shared types and default sizes for the voice allocator.
// No logic of its own; state/action encodings are 2 bits.
// Imported by voice_alloc and voice_pick.
package voice_alloc_pkg;

  localparam int NVOICE_DEF = 4;
  localparam int CYC_W_DEF  = 16;
  localparam int AGE_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ACT_NONE = 2'd0,
    ACT_ON   = 2'd1,
    ACT_OFF  = 2'd2
  } act_t;

  // Width of a voice index; a 1-voice build still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/voice_pick.sv
// Combinational voice selector: matching active voice, lowest free voice, oldest active voice.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller registers the result.
module voice_pick import voice_alloc_pkg::*; #(
  parameter int NVOICE = NVOICE_DEF,
  parameter int CYC_W  = CYC_W_DEF,
  parameter int AGE_W  = AGE_W_DEF,
  parameter int IDX_W  = idx_width(NVOICE)
) (
  input  logic [NVOICE-1:0]       active,
  input  logic [NVOICE*CYC_W-1:0] cyc,
  input  logic [NVOICE*AGE_W-1:0] age,
  input  logic [CYC_W-1:0]        ev_cyc,
  output logic                    match_hit,
  output logic [IDX_W-1:0]        match_idx,
  output logic                    free_hit,
  output logic [IDX_W-1:0]        free_idx,
  output logic [IDX_W-1:0]        oldest_idx
);

  logic [AGE_W-1:0] best_age;
  logic             best_vld;

  // Match and free scans run high-to-low so the lowest index is written last and wins.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = NVOICE - 1; i >= 0; i--) begin
      if (active[i] && (cyc[i*CYC_W +: CYC_W] == ev_cyc)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!active[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Oldest active voice; strict greater-than keeps the lowest index on an age tie.
  always_comb begin
    oldest_idx = '0;
    best_age   = '0;
    best_vld   = 1'b0;
    for (int i = 0; i < NVOICE; i++) begin
      if (active[i] && (!best_vld || (age[i*AGE_W +: AGE_W] > best_age))) begin
        best_vld   = 1'b1;
        best_age   = age[i*AGE_W +: AGE_W];
        oldest_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice scheduler: maps note-on/off events onto NVOICE synthesis voice slices.
// Latency: event accepted at T, voice outputs and steal pulse visible at T+3.
// Backpressure: ev_ready high only in IDLE, so at most one event per 3 cycles; source holds the event.
module voice_alloc import voice_alloc_pkg::*; #(
  parameter int NVOICE = NVOICE_DEF,
  parameter int CYC_W  = CYC_W_DEF,
  parameter int AGE_W  = AGE_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    ev_valid,
  output logic                    ev_ready,
  input  logic                    ev_on,
  input  logic [CYC_W-1:0]        ev_cyc,
  output logic [NVOICE*CYC_W-1:0] voice_cyc,
  output logic [NVOICE-1:0]       voice_attack,
  output logic [NVOICE-1:0]       voice_active,
  output logic                    steal
);

  localparam int               IDX_W   = idx_width(NVOICE);
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  state_t state_q, state_d;

  // Captured event
  logic             ev_on_q;
  logic [CYC_W-1:0] ev_cyc_q;

  // Decision registered in SEARCH, applied in COMMIT
  act_t             act_q;
  logic [IDX_W-1:0] idx_q;
  logic             steal_pend_q;

  // Per-voice state
  logic [NVOICE*CYC_W-1:0] cyc_q;
  logic [NVOICE*AGE_W-1:0] age_q;
  logic [NVOICE-1:0]       active_q;
  logic [NVOICE-1:0]       attack_q;
  logic                    steal_q;

  logic             match_hit, free_hit;
  logic [IDX_W-1:0] match_idx, free_idx, oldest_idx;

  voice_pick #(
    .NVOICE (NVOICE),
    .CYC_W  (CYC_W),
    .AGE_W  (AGE_W),
    .IDX_W  (IDX_W)
  ) u_pick (
    .active     (active_q),
    .cyc        (cyc_q),
    .age        (age_q),
    .ev_cyc     (ev_cyc_q),
    .match_hit  (match_hit),
    .match_idx  (match_idx),
    .free_hit   (free_hit),
    .free_idx   (free_idx),
    .oldest_idx (oldest_idx)
  );

  // Gated by rst so no event is offered while the block is held in reset.
  assign ev_ready     = (state_q == ST_IDLE) && !rst;
  assign voice_cyc    = cyc_q;
  assign voice_attack = attack_q;
  assign voice_active = active_q;
  assign steal        = steal_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: IDLE -> SEARCH on transfer, then COMMIT, then back to IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (ev_valid) state_d = ST_SEARCH;
      ST_SEARCH: state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Event capture in IDLE and voice decision in SEARCH
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_on_q      <= 1'b0;
      ev_cyc_q     <= '0;
      act_q        <= ACT_NONE;
      idx_q        <= '0;
      steal_pend_q <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && ev_valid) begin
        ev_on_q  <= ev_on;
        ev_cyc_q <= ev_cyc;
      end
      if (state_q == ST_SEARCH) begin
        steal_pend_q <= 1'b0;
        if (ev_on_q) begin
          act_q <= ACT_ON;
          if (match_hit) begin
            idx_q <= match_idx;
          end else if (free_hit) begin
            idx_q <= free_idx;
          end else begin
            idx_q        <= oldest_idx;
            steal_pend_q <= 1'b1;
          end
        end else if (match_hit) begin
          act_q <= ACT_OFF;
          idx_q <= match_idx;
        end else begin
          act_q <= ACT_NONE;
        end
      end
    end
  end

  // Voice state: tick ages and retires attacks; a COMMIT write to a voice overrides the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q    <= '0;
      age_q    <= '0;
      active_q <= '0;
      attack_q <= '0;
      steal_q  <= 1'b0;
    end else begin
      steal_q <= (state_q == ST_COMMIT) && (act_q == ACT_ON) && steal_pend_q;
      if (tick) begin
        for (int i = 0; i < NVOICE; i++) begin
          if (age_q[i*AGE_W +: AGE_W] != AGE_MAX)
            age_q[i*AGE_W +: AGE_W] <= age_q[i*AGE_W +: AGE_W] + AGE_W'(1);
          attack_q[i] <= 1'b0;
        end
      end
      if (state_q == ST_COMMIT) begin
        if (act_q == ACT_ON) begin
          cyc_q[int'(idx_q)*CYC_W +: CYC_W] <= ev_cyc_q;
          age_q[int'(idx_q)*AGE_W +: AGE_W] <= '0;
          active_q[idx_q]                   <= 1'b1;
          attack_q[idx_q]                   <= 1'b1;
        end else if (act_q == ACT_OFF) begin
          // Period is kept so the released note can decay in its envelope.
          active_q[idx_q] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc: allocation order, stealing, release, retrigger and collisions.
// Inputs change and outputs are observed 1 time unit after each rising edge.
// Event timing is fixed by the design: accept at T, results at T+3.
module tb_voice_alloc;

  localparam int NVOICE = 4;
  localparam int CYC_W  = 16;
  localparam int AGE_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    tick = 1'b0;
  logic                    ev_valid = 1'b0;
  logic                    ev_ready;
  logic                    ev_on = 1'b0;
  logic [CYC_W-1:0]        ev_cyc = '0;
  logic [NVOICE*CYC_W-1:0] voice_cyc;
  logic [NVOICE-1:0]       voice_attack;
  logic [NVOICE-1:0]       voice_active;
  logic                    steal;

  int checks   = 0;
  int failures = 0;

  voice_alloc #(.NVOICE(NVOICE), .CYC_W(CYC_W), .AGE_W(AGE_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_on        (ev_on),
    .ev_cyc       (ev_cyc),
    .voice_cyc    (voice_cyc),
    .voice_attack (voice_attack),
    .voice_active (voice_active),
    .steal        (steal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one event for the accept cycle and returns at T+3; optional tick during COMMIT.
  task automatic send(input logic on, input logic [CYC_W-1:0] c, input logic tick_at_commit);
    ev_valid = 1'b1;
    ev_on    = on;
    ev_cyc   = c;
    step();                 // T+1, SEARCH
    ev_valid = 1'b0;
    step();                 // T+2, COMMIT
    tick = tick_at_commit;
    step();                 // T+3
    tick = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({voice_cyc, voice_active, voice_attack, steal, ev_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got cyc=%h act=%b atk=%b steal=%b rdy=%b exp all zero",
               voice_cyc, voice_active, voice_attack, steal, ev_ready);
    end
    rst = 1'b0;
    step();
    checks++;
    if (ev_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", ev_ready);
    end
  endtask

  task automatic test_first_note();
    ev_valid = 1'b1;
    ev_on    = 1'b1;
    ev_cyc   = 16'd1000;
    step();
    ev_valid = 1'b0;
    checks++;
    if (ev_ready !== 1'b0) begin
      failures++;
      $display("FAIL first_ready_t1 got=%b exp=0", ev_ready);
    end
    step();
    checks++;
    if (ev_ready !== 1'b0) begin
      failures++;
      $display("FAIL first_ready_t2 got=%b exp=0", ev_ready);
    end
    step();
    checks++;
    if ({voice_cyc[15:0], voice_active, voice_attack, steal, ev_ready} !== {16'd1000, 4'b0001, 4'b0001, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL first_note got cyc0=%0d act=%b atk=%b steal=%b rdy=%b exp cyc0=1000 act=0001 atk=0001 steal=0 rdy=1",
               voice_cyc[15:0], voice_active, voice_attack, steal, ev_ready);
    end
  endtask

  task automatic test_fill();
    do_reset();
    send(1'b1, 16'd100, 1'b0);
    send(1'b1, 16'd200, 1'b0);
    send(1'b1, 16'd300, 1'b0);
    send(1'b1, 16'd400, 1'b0);
    checks++;
    if ({voice_cyc, voice_active, voice_attack} !== {16'd400, 16'd300, 16'd200, 16'd100, 4'b1111, 4'b1111}) begin
      failures++;
      $display("FAIL fill_order got cyc=%h act=%b atk=%b exp cyc=0190012c00c80064 act=1111 atk=1111",
               voice_cyc, voice_active, voice_attack);
    end
    pulse_tick();
    checks++;
    if ({voice_active, voice_attack} !== {4'b1111, 4'b0000}) begin
      failures++;
      $display("FAIL fill_tick got act=%b atk=%b exp act=1111 atk=0000", voice_active, voice_attack);
    end
  endtask

  task automatic test_steal();
    pulse_tick();
    pulse_tick();
    pulse_tick();
    send(1'b1, 16'd500, 1'b0);
    checks++;
    if ({voice_cyc, voice_active, voice_attack, steal} !== {16'd400, 16'd300, 16'd200, 16'd500, 4'b1111, 4'b0001, 1'b1}) begin
      failures++;
      $display("FAIL steal_voice0 got cyc=%h act=%b atk=%b steal=%b exp cyc=0190012c00c801f4 act=1111 atk=0001 steal=1",
               voice_cyc, voice_active, voice_attack, steal);
    end
    checks++;
    if (dut.age_q !== {8'd4, 8'd4, 8'd4, 8'd0}) begin
      failures++;
      $display("FAIL steal_age got=%h exp=04040400", dut.age_q);
    end
    step();
    checks++;
    if (steal !== 1'b0) begin
      failures++;
      $display("FAIL steal_one_cycle got=%b exp=0", steal);
    end
  endtask

  task automatic test_release();
    logic [NVOICE*CYC_W-1:0] cyc_before;
    logic [NVOICE-1:0]       act_before, atk_before;
    send(1'b0, 16'd200, 1'b0);
    checks++;
    if ({voice_active, voice_cyc[31:16], voice_attack} !== {4'b1101, 16'd200, 4'b0001}) begin
      failures++;
      $display("FAIL release_200 got act=%b cyc1=%0d atk=%b exp act=1101 cyc1=200 atk=0001",
               voice_active, voice_cyc[31:16], voice_attack);
    end
    send(1'b1, 16'd600, 1'b0);
    checks++;
    if ({voice_active, voice_cyc, voice_attack, steal} !== {4'b1111, 16'd400, 16'd300, 16'd600, 16'd500, 4'b0011, 1'b0}) begin
      failures++;
      $display("FAIL free_reuse got act=%b cyc=%h atk=%b steal=%b exp act=1111 cyc=0190012c025801f4 atk=0011 steal=0",
               voice_active, voice_cyc, voice_attack, steal);
    end
    cyc_before = {16'd400, 16'd300, 16'd600, 16'd500};
    act_before = 4'b1111;
    atk_before = 4'b0011;
    send(1'b0, 16'd999, 1'b0);
    checks++;
    if ({voice_cyc, voice_active, voice_attack, steal} !== {cyc_before, act_before, atk_before, 1'b0}) begin
      failures++;
      $display("FAIL release_nomatch got cyc=%h act=%b atk=%b steal=%b exp unchanged",
               voice_cyc, voice_active, voice_attack, steal);
    end
  endtask

  task automatic test_retrigger();
    pulse_tick();   // ages 1,1,5,5 ; attacks cleared
    send(1'b1, 16'd300, 1'b0);
    checks++;
    if ({voice_cyc, voice_active, voice_attack, steal} !== {16'd400, 16'd300, 16'd600, 16'd500, 4'b1111, 4'b0100, 1'b0}) begin
      failures++;
      $display("FAIL retrigger got cyc=%h act=%b atk=%b steal=%b exp cyc=0190012c025801f4 act=1111 atk=0100 steal=0",
               voice_cyc, voice_active, voice_attack, steal);
    end
    checks++;
    if (dut.age_q !== {8'd5, 8'd0, 8'd1, 8'd1}) begin
      failures++;
      $display("FAIL retrigger_age got=%h exp=05000101", dut.age_q);
    end
  endtask

  task automatic test_tick_commit();
    send(1'b1, 16'd400, 1'b1);
    checks++;
    if (voice_attack !== 4'b1000) begin
      failures++;
      $display("FAIL tick_commit_attack got=%b exp=1000", voice_attack);
    end
    checks++;
    if (dut.age_q !== {8'd0, 8'd1, 8'd2, 8'd2}) begin
      failures++;
      $display("FAIL tick_commit_age got=%h exp=00010202", dut.age_q);
    end
    pulse_tick();
    checks++;
    if (voice_attack !== 4'b0000) begin
      failures++;
      $display("FAIL tick_after_commit got=%b exp=0000", voice_attack);
    end
  endtask

  task automatic test_reset_mid();
    ev_valid = 1'b1;
    ev_on    = 1'b1;
    ev_cyc   = 16'd700;
    step();            // SEARCH
    ev_valid = 1'b0;
    rst = 1'b1;
    step();
    checks++;
    if ({voice_cyc, voice_active, voice_attack, steal, ev_ready} !== '0) begin
      failures++;
      $display("FAIL reset_mid got cyc=%h act=%b atk=%b steal=%b rdy=%b exp all zero",
               voice_cyc, voice_active, voice_attack, steal, ev_ready);
    end
    rst = 1'b0;
    step();
    step();
    step();
    checks++;
    if ({voice_cyc, voice_active, voice_attack, steal, ev_ready} !== {64'd0, 4'b0000, 4'b0000, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid_discard got cyc=%h act=%b atk=%b steal=%b rdy=%b exp cyc=0 act=0000 atk=0000 steal=0 rdy=1",
               voice_cyc, voice_active, voice_attack, steal, ev_ready);
    end
  endtask

  task automatic test_back_to_back();
    ev_valid = 1'b1;
    ev_on    = 1'b1;
    ev_cyc   = 16'd10;
    step();            // T+1: first accepted, second event held by the source
    ev_cyc = 16'd20;
    checks++;
    if (ev_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_busy got=%b exp=0", ev_ready);
    end
    step();
    step();            // T+3
    checks++;
    if ({voice_active, voice_cyc[15:0], ev_ready} !== {4'b0001, 16'd10, 1'b1}) begin
      failures++;
      $display("FAIL b2b_first got act=%b cyc0=%0d rdy=%b exp act=0001 cyc0=10 rdy=1",
               voice_active, voice_cyc[15:0], ev_ready);
    end
    step();            // second accepted at previous edge
    ev_valid = 1'b0;
    step();
    step();
    checks++;
    if ({voice_active, voice_cyc[31:0]} !== {4'b0011, 16'd20, 16'd10}) begin
      failures++;
      $display("FAIL b2b_second got act=%b cyc=%h exp act=0011 cyc=0014000a",
               voice_active, voice_cyc[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_first_note();
    test_fill();
    test_steal();
    test_release();
    test_retrigger();
    test_tick_commit();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
